// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and datamem.
// slave: arbiter side. master: requester/memory side.
interface dmem_arbiter_if;
    logic        reqa_valid;
    logic        reqa_rw;
    logic [63:0] reqa_addr;
    logic [63:0] reqa_wdata;
    logic        reqa_ready;
    logic        rspa_valid;
    logic [31:0] rspa_rdata;
    logic        rspa_err;
    logic        reqb_valid;
    logic        reqb_rw;
    logic [63:0] reqb_addr;
    logic [63:0] reqb_wdata;
    logic        reqb_ready;
    logic        rspb_valid;
    logic [31:0] rspb_rdata;
    logic        rspb_err;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  reqa_valid, reqa_rw, reqa_addr, reqa_wdata,
        output reqa_ready, rspa_valid, rspa_rdata, rspa_err,
        input  reqb_valid, reqb_rw, reqb_addr, reqb_wdata,
        output reqb_ready, rspb_valid, rspb_rdata, rspb_err,
        output mem_addr, mem_wdata, mem_en, mem_rw, busy,
        input  mem_rdata
    );

    modport master (
        output reqa_valid, reqa_rw, reqa_addr, reqa_wdata,
        input  reqa_ready, rspa_valid, rspa_rdata, rspa_err,
        output reqb_valid, reqb_rw, reqb_addr, reqb_wdata,
        input  reqb_ready, rspb_valid, rspb_rdata, rspb_err,
        input  mem_addr, mem_wdata, mem_en, mem_rw, busy,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for datamem: A = CPU, B = loader.
// Ports: clk, rst (async active-low), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
    parameter int DEPTH   = 65536,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [63:0] LIMIT = 64'(DEPTH);
    localparam logic [3:0]  LAT   = 4'(MEM_LAT);

    state_t      state;
    state_t      state_n;
    logic        last_b;
    logic        id_b;
    logic        rw_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [3:0]  cnt;

    logic        gnt_a;
    logic        gnt_b;
    logic        acc_a;
    logic        acc_b;
    logic        accept;
    logic [63:0] sel_addr;
    logic        in_range;
    logic        rsp;

    // On a conflict the side that was not served last wins.
    assign gnt_a = bus.reqa_valid & (~bus.reqb_valid | last_b);
    assign gnt_b = bus.reqb_valid & (~bus.reqa_valid | ~last_b);
    assign acc_a = rst & (state == IDLE) & gnt_a;
    assign acc_b = rst & (state == IDLE) & gnt_b;
    assign accept = acc_a | acc_b;

    assign sel_addr = acc_b ? bus.reqb_addr : bus.reqa_addr;
    assign in_range = sel_addr < LIMIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = in_range ? ISSUE : RESP;
            ISSUE:   state_n = WAIT;
            WAIT:    if (cnt == 4'd1) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b  <= 1'b1;
            id_b    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                last_b  <= acc_b;
                id_b    <= acc_b;
                rw_q    <= acc_b ? bus.reqb_rw : bus.reqa_rw;
                addr_q  <= sel_addr;
                wdata_q <= acc_b ? bus.reqb_wdata : bus.reqa_wdata;
                err_q   <= ~in_range;
                rdata_q <= '0;
            end
            if (state == ISSUE) begin
                cnt <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                // Writes return zero data.
                if (cnt == 4'd1)
                    rdata_q <= rw_q ? 32'd0 : bus.mem_rdata;
            end
        end
    end

    // Bus fields come straight from the latched request, so they
    // hold from ISSUE until the next accept.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rw    = rw_q;
    assign bus.mem_en    = (state == ISSUE);
    assign bus.busy      = (state != IDLE);

    assign bus.reqa_ready = acc_a;
    assign bus.reqb_ready = acc_b;

    assign rsp            = (state == RESP);
    assign bus.rspa_valid = rsp & ~id_b;
    assign bus.rspb_valid = rsp & id_b;
    assign bus.rspa_rdata = bus.rspa_valid ? rdata_q : 32'd0;
    assign bus.rspb_rdata = bus.rspb_valid ? rdata_q : 32'd0;
    assign bus.rspa_err   = bus.rspa_valid & err_q;
    assign bus.rspb_err   = bus.rspb_valid & err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: MEM_LAT=1 and MEM_LAT=4 instances.
// Table-driven per-cycle vectors plus directed multi-cycle sequences.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if if1();
    dmem_arbiter_if if4();

    dmem_arbiter #(.DEPTH(65536), .MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst_n), .bus(if1)
    );
    dmem_arbiter #(.DEPTH(65536), .MEM_LAT(4)) u4 (
        .clk(clk), .rst(rst_n), .bus(if4)
    );

    // ctl = {ready_a, ready_b, mem_en, mem_rw, busy}
    // rsp = {rspa_valid, rspa_err, rspb_valid, rspb_err}
    typedef struct packed {
        logic [4:0]  ctl;
        logic [63:0] maddr;
        logic [63:0] mwd;
        logic [3:0]  rsp;
        logic [31:0] rda;
        logic [31:0] rdb;
    } obs_t;

    // req = {a_valid, a_rw, b_valid, b_rw}
    typedef struct packed {
        logic [3:0]  req;
        logic [63:0] aaddr;
        logic [63:0] baddr;
        logic [63:0] bwd;
        logic [31:0] mrd;
        obs_t        exp;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic clr();
        if1.reqa_valid = 0; if1.reqa_rw = 0;
        if1.reqa_addr = '0; if1.reqa_wdata = '0;
        if1.reqb_valid = 0; if1.reqb_rw = 0;
        if1.reqb_addr = '0; if1.reqb_wdata = '0;
        if1.mem_rdata = '0;
        if4.reqa_valid = 0; if4.reqa_rw = 0;
        if4.reqa_addr = '0; if4.reqa_wdata = '0;
        if4.reqb_valid = 0; if4.reqb_rw = 0;
        if4.reqb_addr = '0; if4.reqb_wdata = '0;
        if4.mem_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    obs_t        o;
    int          ng, nr, nb, ne, en_at, rsp_at;
    logic        expb, seen, re, ga, gb;
    logic [31:0] rd, got;
    logic        sb_b [8];
    logic [31:0] sb_d [8];

    initial begin
        vecs[0]  = {4'b1000, 64'h10, 64'h0, 64'h0, 32'h0,
                    5'b10000, 64'h0, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[1]  = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h0,
                    5'b00101, 64'h10, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[2]  = {4'b0000, 64'h0, 64'h0, 64'h0, 32'hDEADBEEF,
                    5'b00001, 64'h10, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[3]  = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h0,
                    5'b00001, 64'h10, 64'h0, 4'b1000, 32'hDEADBEEF, 32'h0};
        vecs[4]  = {4'b0011, 64'h0, 64'h20, 64'h1234, 32'h0,
                    5'b01000, 64'h10, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[5]  = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h0,
                    5'b00111, 64'h20, 64'h1234, 4'b0000, 32'h0, 32'h0};
        vecs[6]  = {4'b0000, 64'h0, 64'h0, 64'h0, 32'hFFFFFFFF,
                    5'b00011, 64'h20, 64'h1234, 4'b0000, 32'h0, 32'h0};
        vecs[7]  = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h0,
                    5'b00011, 64'h20, 64'h1234, 4'b0010, 32'h0, 32'h0};
        vecs[8]  = {4'b1000, 64'h10000, 64'h0, 64'h0, 32'h0,
                    5'b10010, 64'h20, 64'h1234, 4'b0000, 32'h0, 32'h0};
        vecs[9]  = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h77777777,
                    5'b00001, 64'h10000, 64'h0, 4'b1100, 32'h0, 32'h0};
        vecs[10] = {4'b1000, 64'hFFFF, 64'h0, 64'h0, 32'h0,
                    5'b10000, 64'h10000, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[11] = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h0,
                    5'b00101, 64'hFFFF, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[12] = {4'b0000, 64'h0, 64'h0, 64'h0, 32'hCAFEF00D,
                    5'b00001, 64'hFFFF, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[13] = {4'b0010, 64'h0, 64'h30, 64'h0, 32'h0,
                    5'b00001, 64'hFFFF, 64'h0, 4'b1000, 32'hCAFEF00D, 32'h0};
        vecs[14] = {4'b0010, 64'h0, 64'h30, 64'h0, 32'h0,
                    5'b01000, 64'hFFFF, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[15] = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h0,
                    5'b00101, 64'h30, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[16] = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h55,
                    5'b00001, 64'h30, 64'h0, 4'b0000, 32'h0, 32'h0};
        vecs[17] = {4'b0000, 64'h0, 64'h0, 64'h0, 32'h0,
                    5'b00001, 64'h30, 64'h0, 4'b0010, 32'h0, 32'h55};

        clr();
        if1.reqa_valid = 1;
        if4.reqb_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u1", {if1.reqa_ready, if1.reqb_ready, if1.mem_en,
                       if1.mem_rw, if1.busy, if1.rspa_valid,
                       if1.rspb_valid, if1.mem_addr}, '0);
        chk("rst_u4", {if4.reqa_ready, if4.reqb_ready, if4.mem_en,
                       if4.mem_rw, if4.busy, if4.rspa_valid,
                       if4.rspb_valid, if4.mem_wdata}, '0);
        clr();
        rst_n = 1;
        tick();

        for (int i = 0; i < 18; i++) begin
            if1.reqa_valid = vecs[i].req[3];
            if1.reqa_rw    = vecs[i].req[2];
            if1.reqb_valid = vecs[i].req[1];
            if1.reqb_rw    = vecs[i].req[0];
            if1.reqa_addr  = vecs[i].aaddr;
            if1.reqb_addr  = vecs[i].baddr;
            if1.reqb_wdata = vecs[i].bwd;
            if1.mem_rdata  = vecs[i].mrd;
            #1;
            o = {if1.reqa_ready, if1.reqb_ready, if1.mem_en, if1.mem_rw,
                 if1.busy, if1.mem_addr, if1.mem_wdata, if1.rspa_valid,
                 if1.rspa_err, if1.rspb_valid, if1.rspb_err,
                 if1.rspa_rdata, if1.rspb_rdata};
            checks++;
            if (o !== vecs[i].exp) begin
                failures++;
                $display("FAIL vec%0d got=%h want=%h", i, o, vecs[i].exp);
            end
            tick();
        end
        clr();

        // Both requesters hold valid: grants must alternate from A.
        ng = 0; nr = 0; expb = 0;
        for (int c = 0; c < 80 && nr < 6; c++) begin
            if1.reqa_valid = (ng < 6);
            if1.reqb_valid = (ng < 6);
            if1.reqa_addr  = 64'h100 + 64'(ng);
            if1.reqb_addr  = 64'h200 + 64'(ng);
            if1.mem_rdata  = if1.mem_addr[31:0] ^ 32'h5A5A0000;
            #1;
            if (if1.rspa_valid || if1.rspb_valid) begin
                got = if1.rspb_valid ? if1.rspb_rdata : if1.rspa_rdata;
                chk($sformatf("arb_rsp%0d", nr),
                    {if1.rspa_valid, if1.rspb_valid, got},
                    {~sb_b[nr], sb_b[nr], sb_d[nr]});
                nr++;
            end
            if (if1.reqa_ready || if1.reqb_ready) begin
                chk($sformatf("arb_gnt%0d", ng),
                    {if1.reqa_ready, if1.reqb_ready}, {~expb, expb});
                sb_b[ng] = expb;
                sb_d[ng] = (expb ? (32'h200 + 32'(ng))
                                 : (32'h100 + 32'(ng))) ^ 32'h5A5A0000;
                expb = ~expb;
                ng++;
            end
            tick();
        end
        if (nr < 6) chk("arb_timeout", 128'(nr), 128'd6);
        clr();

        // MEM_LAT=4: only the 4th cycle after mem_en is captured.
        if4.reqa_valid = 1;
        if4.reqa_addr  = 64'h40;
        #1;
        chk("l4_rdy", if4.reqa_ready, 1);
        tick();
        if4.reqa_valid = 0;
        nb = 0; ne = 0; en_at = 0; rsp_at = 0; rd = '0; re = 1;
        for (int k = 1; k <= 10; k++) begin
            if4.mem_rdata = (k == 5) ? 32'h600D600D
                                     : (32'hBAD00000 | 32'(k));
            #1;
            if (if4.busy) nb++;
            if (if4.mem_en) begin ne++; en_at = k; end
            if (if4.rspa_valid) begin
                rsp_at = k; rd = if4.rspa_rdata; re = if4.rspa_err;
            end
            tick();
        end
        chk("l4_en_cnt", 128'(ne), 128'd1);
        chk("l4_en_at", 128'(en_at), 128'd1);
        chk("l4_busy", 128'(nb), 128'd6);
        chk("l4_rsp_at", 128'(rsp_at), 128'd6);
        chk("l4_data", {re, rd}, {1'b0, 32'h600D600D});
        clr();

        // Reset during WAIT drops the request.
        if1.reqa_valid = 1;
        if1.reqa_addr  = 64'h80;
        if1.mem_rdata  = 32'h11111111;
        tick();
        if1.reqa_valid = 0;
        tick();
        rst_n = 0;
        if1.reqa_valid = 1;
        if1.reqb_valid = 1;
        #1;
        chk("rst_mid", {if1.reqa_ready, if1.reqb_ready, if1.mem_en,
                        if1.mem_rw, if1.busy, if1.rspa_valid,
                        if1.rspb_valid, if1.rspa_err, if1.rspb_err,
                        if1.rspa_rdata, if1.rspb_rdata}, '0);
        chk("rst_bus", {if1.mem_addr, if1.mem_wdata}, '0);
        seen = 0;
        repeat (3) begin
            tick();
            if (if1.rspa_valid || if1.rspb_valid) seen = 1;
        end
        rst_n = 1;
        if1.reqa_addr = 64'h90;
        if1.reqb_addr = 64'hA0;
        if1.mem_rdata = 32'h0BADCAFE;
        #1;
        chk("rst_arb", {if1.reqa_ready, if1.reqb_ready}, 2'b10);
        tick();
        if1.reqa_valid = 0;
        if1.reqb_valid = 0;
        ga = 0; gb = 0; rd = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (if1.rspb_valid) gb = 1;
            if (if1.rspa_valid) begin ga = 1; rd = if1.rspa_rdata; end
            tick();
        end
        chk("rst_norsp", seen, 0);
        chk("rst_rsp", {ga, gb, rd}, {1'b1, 1'b0, 32'h0BADCAFE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
